// File: rtl/md_unit.sv
// Multiply/divide unit for the EX stage; owns the HI/LO registers.
// Latency: mthi/mtlo write at the accepting edge; mult/div commit MULT_CYCLES/DIV_CYCLES edges later.
// Backpressure: Busy is high while an op is in flight; any Start seen while Busy is dropped.
module md_unit #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Start,
   input  logic [31:0] MD_Op,
   input  logic        Flush,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        Busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   localparam logic [31:0] OP_MULT  = 32'd1;
   localparam logic [31:0] OP_MULTU = 32'd2;
   localparam logic [31:0] OP_DIV   = 32'd3;
   localparam logic [31:0] OP_DIVU  = 32'd4;
   localparam logic [31:0] OP_MTHI  = 32'd5;
   localparam logic [31:0] OP_MTLO  = 32'd6;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t        state, state_nxt;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [31:0]   hi_q, hi_nxt;
   logic [31:0]   lo_q, lo_nxt;
   logic [31:0]   pend_hi, pend_hi_nxt;
   logic [31:0]   pend_lo, pend_lo_nxt;
   logic          pend_ok, pend_ok_nxt;

   logic is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
   logic is_md_op, accept;

   logic [63:0] mul_a, mul_b, prod;
   logic        a_neg, b_neg, div_zero;
   logic [31:0] a_mag, b_mag, b_safe;
   logic [31:0] uq, ur, quot, rem;

   // Decode the opcode and qualify Start: flushed, busy or unknown-op strobes are ignored.
   always_comb begin
      is_mult  = (MD_Op == OP_MULT);
      is_multu = (MD_Op == OP_MULTU);
      is_div   = (MD_Op == OP_DIV);
      is_divu  = (MD_Op == OP_DIVU);
      is_mthi  = (MD_Op == OP_MTHI);
      is_mtlo  = (MD_Op == OP_MTLO);
      is_md_op = is_mult | is_multu | is_div | is_divu | is_mthi | is_mtlo;
      accept   = Start && !Flush && (state == ST_IDLE) && is_md_op;
   end

   // 64-bit product: sign- or zero-extend both operands so the low 64 bits are exact either way.
   always_comb begin
      mul_a = is_mult ? {{32{A[31]}}, A} : {32'b0, A};
      mul_b = is_mult ? {{32{B[31]}}, B} : {32'b0, B};
      prod  = mul_a * mul_b;
   end

   // Divide on magnitudes and fix signs afterwards; this also yields 0x80000000 / -1 = 0x80000000, rem 0.
   always_comb begin
      a_neg    = is_div & A[31];
      b_neg    = is_div & B[31];
      a_mag    = a_neg ? (32'd0 - A) : A;
      b_mag    = b_neg ? (32'd0 - B) : B;
      div_zero = (B == 32'd0);
      b_safe   = div_zero ? 32'd1 : b_mag;
      uq       = a_mag / b_safe;
      ur       = a_mag % b_safe;
      quot     = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
      rem      = a_neg ? (32'd0 - ur) : ur;
   end

   // Next-state logic: accept in IDLE, count down in RUN, commit the pending result on the last count.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      hi_nxt      = hi_q;
      lo_nxt      = lo_q;
      pend_hi_nxt = pend_hi;
      pend_lo_nxt = pend_lo;
      pend_ok_nxt = pend_ok;

      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mthi) begin
                  hi_nxt = A;
               end else if (is_mtlo) begin
                  lo_nxt = A;
               end else if (is_mult || is_multu) begin
                  pend_hi_nxt = prod[63:32];
                  pend_lo_nxt = prod[31:0];
                  pend_ok_nxt = 1'b1;
                  cnt_nxt     = CW'(MULT_CYCLES);
                  state_nxt   = ST_RUN;
               end else begin
                  // Divide by zero still occupies the unit for the full latency but never commits.
                  pend_hi_nxt = rem;
                  pend_lo_nxt = quot;
                  pend_ok_nxt = !div_zero;
                  cnt_nxt     = CW'(DIV_CYCLES);
                  state_nxt   = ST_RUN;
               end
            end
         end
         ST_RUN: begin
            if (cnt == CW'(1)) begin
               if (pend_ok) begin
                  hi_nxt = pend_hi;
                  lo_nxt = pend_lo;
               end
               pend_ok_nxt = 1'b0;
               cnt_nxt     = '0;
               state_nxt   = ST_IDLE;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         default: begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // State and architectural registers; reset aborts any in-flight op immediately.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         hi_q    <= 32'd0;
         lo_q    <= 32'd0;
         pend_hi <= 32'd0;
         pend_lo <= 32'd0;
         pend_ok <= 1'b0;
      end else begin
         state   <= state_nxt;
         cnt     <= cnt_nxt;
         hi_q    <= hi_nxt;
         lo_q    <= lo_nxt;
         pend_hi <= pend_hi_nxt;
         pend_lo <= pend_lo_nxt;
         pend_ok <= pend_ok_nxt;
      end
   end

   // Outputs come straight from registers; nothing from A/B reaches HI/LO combinationally.
   always_comb begin
      Busy = (state == ST_RUN);
      HI   = hi_q;
      LO   = lo_q;
   end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: a vector table of ops with expected HI/LO and Busy length,
// followed by hand-written sequences for flush, start-while-busy and mid-op reset.
module tb_md_unit;

   logic        clk;
   logic        reset;
   logic        Start;
   logic [31:0] MD_Op;
   logic        Flush;
   logic [31:0] A;
   logic [31:0] B;
   logic        Busy;
   logic [31:0] HI;
   logic [31:0] LO;

   int errors = 0;
   int checks = 0;

   md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk   (clk),
      .reset (reset),
      .Start (Start),
      .MD_Op (MD_Op),
      .Flush (Flush),
      .A     (A),
      .B     (B),
      .Busy  (Busy),
      .HI    (HI),
      .LO    (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] op;
      logic [31:0] a;
      logic [31:0] b;
      int          cyc;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vt[$];

   task automatic add_vec(input string name, input logic [31:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input logic [31:0] hi,
                          input logic [31:0] lo);
      vec_t v;
      v.name = name; v.op = op; v.a = a; v.b = b; v.cyc = cyc; v.hi = hi; v.lo = lo;
      vt.push_back(v);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Called just after a falling edge: present one Start for one rising edge, then
   // return at the following falling edge with Start released.
   task automatic issue(input logic [31:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic fl);
      Start = 1'b1; MD_Op = op; A = a; B = b; Flush = fl;
      @(negedge clk);
      Start = 1'b0; MD_Op = 32'd0; Flush = 1'b0;
   endtask

   // Count falling edges on which Busy is high, bounded so a stuck Busy cannot hang the run.
   task automatic count_busy(output int n);
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
   endtask

   initial begin
      int n;
      int seen;

      reset = 1'b0; Start = 1'b0; MD_Op = 32'd0; Flush = 1'b0; A = 32'd0; B = 32'd0;

      // Table: HI/LO state carries from one row to the next.
      add_vec("mthi",          32'd5, 32'h12345678, 32'h0,        0,  32'h12345678, 32'h00000000);
      add_vec("mult -2*3",     32'd1, 32'hFFFFFFFE, 32'h3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA);
      add_vec("multu fffe*3",  32'd2, 32'hFFFFFFFE, 32'h3,        5,  32'h00000002, 32'hFFFFFFFA);
      add_vec("div -7/2",      32'd3, 32'hFFFFFFF9, 32'h2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD);
      add_vec("divu 7/2",      32'd4, 32'h7,        32'h2,        10, 32'h00000001, 32'h00000003);
      add_vec("div ovf",       32'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000);
      add_vec("mthi aa",       32'd5, 32'hAAAAAAAA, 32'h0,        0,  32'hAAAAAAAA, 32'h80000000);
      add_vec("mtlo aa",       32'd6, 32'hAAAAAAAA, 32'h0,        0,  32'hAAAAAAAA, 32'hAAAAAAAA);
      add_vec("divu by 0",     32'd4, 32'h5,        32'h0,        10, 32'hAAAAAAAA, 32'hAAAAAAAA);
      add_vec("multu max",     32'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001);
      add_vec("mult -1*-1",    32'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'h00000000, 32'h00000001);
      add_vec("mult 7fff^2",   32'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001);
      add_vec("div -7/-2",     32'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 10, 32'hFFFFFFFF, 32'h00000003);
      add_vec("div 7/-2",      32'd3, 32'h7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD);
      add_vec("div by 0",      32'd3, 32'h9,        32'h0,        10, 32'h00000001, 32'hFFFFFFFD);
      add_vec("op 7 ignored",  32'd7, 32'h1234,     32'h5,        0,  32'h00000001, 32'hFFFFFFFD);
      add_vec("op 0 ignored",  32'd0, 32'h1234,     32'h5,        0,  32'h00000001, 32'hFFFFFFFD);
      add_vec("mtlo 0",        32'd6, 32'h0,        32'h0,        0,  32'h00000001, 32'h00000000);

      repeat (3) @(negedge clk);
      chk("reset busy", {31'b0, Busy}, 32'd0);
      chk("reset hi", HI, 32'd0);
      chk("reset lo", LO, 32'd0);
      reset = 1'b1;
      @(negedge clk);

      foreach (vt[i]) begin
         issue(vt[i].op, vt[i].a, vt[i].b, 1'b0);
         count_busy(n);
         chk({vt[i].name, " busy"}, 32'(n), 32'(vt[i].cyc));
         chk({vt[i].name, " hi"}, HI, vt[i].hi);
         chk({vt[i].name, " lo"}, LO, vt[i].lo);
         @(negedge clk);
      end

      // Flush in the same cycle as Start squashes the op.
      issue(32'd1, 32'h3, 32'h4, 1'b1);
      count_busy(n);
      chk("flushed mult busy", 32'(n), 32'd0);
      chk("flushed mult hi", HI, 32'h00000001);
      chk("flushed mult lo", LO, 32'h00000000);

      // Flush while a divide is in flight does not cancel it.
      issue(32'd4, 32'd100, 32'd7, 1'b0);
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         n++;
         Flush = (n >= 3 && n <= 5);
         @(negedge clk);
      end
      Flush = 1'b0;
      chk("flush mid-div busy", 32'(n), 32'd10);
      chk("flush mid-div hi", HI, 32'd2);
      chk("flush mid-div lo", LO, 32'd14);

      // Start held high through every busy cycle, commit cycle included, is dropped.
      issue(32'd1, 32'h3, 32'h4, 1'b0);
      Start = 1'b1; MD_Op = 32'd6; A = 32'hDEAD;
      n = 0;
      while (Busy === 1'b1 && n < 40) begin
         n++;
         @(negedge clk);
      end
      Start = 1'b0; MD_Op = 32'd0;
      chk("start-while-busy busy", 32'(n), 32'd5);
      chk("start-while-busy hi", HI, 32'd0);
      chk("start-while-busy lo", LO, 32'd12);
      @(negedge clk);
      chk("start-while-busy after", {31'b0, Busy}, 32'd0);

      // Reset three cycles into a multiply clears everything at once, with no later commit.
      issue(32'd1, 32'h10000, 32'h10000, 1'b0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("async reset busy", {31'b0, Busy}, 32'd0);
      chk("async reset hi", HI, 32'd0);
      chk("async reset lo", LO, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (Busy !== 1'b0) seen++;
      end
      chk("post-reset busy seen", 32'(seen), 32'd0);
      chk("post-reset hi", HI, 32'd0);
      chk("post-reset lo", LO, 32'd0);
      issue(32'd6, 32'h55, 32'h0, 1'b0);
      chk("post-reset mtlo busy", {31'b0, Busy}, 32'd0);
      chk("post-reset mtlo hi", HI, 32'd0);
      chk("post-reset mtlo lo", LO, 32'h55);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
